bitonic_sort_ctrl: RTL and testbench
====================================

BITONIC_SORT_CTRL -- requirements
Module: bitonic_sort_ctrl

Interface
REQ-001 SHALL have parameter SORT_SIZE, default `SORT_SIZE, elements per vector (power of 2, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, bits per element, unsigned.
REQ-003 SHALL have parameter SORT_LATENCY, default 3, clock edges from bitonic_sorter input change to matching stable output (>=1).
REQ-004 SHALL have parameter OUT_DEPTH, default 4, output FIFO entries (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  producer offers in_data.
REQ-008 SHALL have port in_ready  output  1  controller accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  SORT_SIZE x DATA_WIDTH  unsorted vector; element i = in_data[i].
REQ-010 SHALL have port out_valid  output  1  out_data holds a sorted vector.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-012 SHALL have port out_data  output  SORT_SIZE x DATA_WIDTH  sorted vector, ascending: element 0 smallest.
REQ-013 SHALL have port flush  input  1  discard all in-flight and buffered vectors.

Function
REQ-014 Transfer SHALL occur on an edge where valid && ready on the same side.
REQ-015 Accepted in_data SHALL be registered into the sorter input register, which SHALL hold its value between transfers.
REQ-016 A valid shift chain of length SORT_LATENCY SHALL track in-flight vectors; at the tail, the sorter output SHALL be written to the FIFO.
REQ-017 Latency: accept at edge k, FIFO empty -> out_valid high after edge k+SORT_LATENCY+1.
REQ-018 in_ready SHALL be registered: high only in state RUN when inflight + fifo_count + (accept this edge) < OUT_DEPTH; no combinational path from out_ready or in_valid.
REQ-019 FIFO SHALL therefore never overflow; FIFO push and pop on the same edge SHALL leave count unchanged.
REQ-020 out_valid = FIFO non-empty in state RUN; out_data = FIFO head; output order = acceptance order.
REQ-021 States: RUN, DRAIN, CLEAR. RUN -> DRAIN on flush. DRAIN: in_ready=0, out_valid=0, sorter outputs reaching the tail are discarded; DRAIN -> CLEAR when inflight==0. CLEAR: FIFO emptied in one cycle -> RUN.
REQ-022 flush in DRAIN/CLEAR SHALL be ignored; flush coincident with a transfer in RUN SHALL discard that vector too.
REQ-023 inflight and fifo_count SHALL be wide enough for their maxima; no wrap-around.

Reset
REQ-024 On rst: state=RUN, in_ready=0 (rises at next edge), out_valid=0, valid chain cleared, FIFO empty, sorter input register=0, counters=0.
REQ-025 rst mid-operation SHALL drop all in-flight vectors; none SHALL appear at the output afterwards.

Configuration
REQ-026 Macro SORT_CTRL_STATS_EN defined: add outputs sort_count (32, increments per output transfer) and stall_count (32, increments per cycle with in_valid && !in_ready in RUN); both saturate at all-ones and clear on rst.
REQ-027 Macro undefined: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-028 Package sort_pkg SHALL hold the vector typedef (SORT_SIZE x DATA_WIDTH), the state enum, and default SORT_LATENCY/OUT_DEPTH constants.
REQ-029 The controller SHALL instantiate the existing bitonic_sorter (clk, data_in, data_out) and one new sub-module sort_out_fifo (parameterized OUT_DEPTH, vector-wide).

Verification (SORT_SIZE=4, DATA_WIDTH=8, SORT_LATENCY=3, OUT_DEPTH=4)
REQ-030 Single vector {9,3,7,1} accepted at edge k -> out_data {1,3,7,9}, out_valid high after edge k+4.
REQ-031 in_valid held high, out_ready=0 -> exactly 4 accepted, in_ready low; one pop -> one more accepted.
REQ-032 20 random vectors, out_ready random 50% -> all 20 out, sorted, in order, none lost or duplicated.
REQ-033 flush with 2 in flight and 1 in FIFO -> no outputs; in_ready high again 1 cycle after DRAIN exits.
REQ-034 rst asserted with 3 in flight -> out_valid=0 after that edge and no stale vector ever emerges.
REQ-035 SORT_CTRL_STATS_EN, 5 transfers with 2 stall cycles -> sort_count=5, stall_count=2.

Source files
------------

// File: rtl/bitonic_sort_ctrl_pkg.sv
// sort_pkg: shared vector type, controller state encoding and default sizing.
// SORT_SIZE / DATA_WIDTH macros fall back to 4 / 8 when not supplied by the build.
`ifndef SORT_SIZE
`define SORT_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
package sort_pkg;
    localparam int SORT_LATENCY_DEF = 3;
    localparam int OUT_DEPTH_DEF = 4;
    typedef logic [`SORT_SIZE-1:0][`DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;
endpackage

// File: rtl/bitonic_sorter.sv
// bitonic_sorter: ascending bitonic compare-exchange network feeding a SORT_LATENCY-deep register pipeline.
module bitonic_sorter #(
    parameter int SORT_SIZE = `SORT_SIZE,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int SORT_LATENCY = 3
) (
    input  logic                                 clk,
    input  logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] data_in,
    output logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] data_out
);
    logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] w_net;
    logic [SORT_LATENCY-1:0][SORT_SIZE-1:0][DATA_WIDTH-1:0] r_pipe;
    // Equal elements may be exchanged; that is a no-op.
    always_comb begin
        w_net = data_in;
        for (int k = 2; k <= SORT_SIZE; k = k * 2)
            for (int j = k / 2; j > 0; j = j / 2)
                for (int i = 0; i < SORT_SIZE; i++)
                    if ((i ^ j) > i && (((i & k) == 0) == (w_net[i] > w_net[i ^ j])))
                        {w_net[i], w_net[i ^ j]} = {w_net[i ^ j], w_net[i]};
    end
    always_ff @(posedge clk) begin
        r_pipe[0] <= w_net;
        for (int i = 1; i < SORT_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign data_out = r_pipe[SORT_LATENCY-1];
endmodule

// File: rtl/sort_out_fifo.sv
// sort_out_fifo: DEPTH-entry FIFO of sorted vectors with a single-cycle clear.
module sort_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) if (i_push) r_mem[r_wp] <= i_data;
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp == AW'(DEPTH - 1) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_data = r_mem[r_rp];
    assign o_count = r_cnt;
endmodule

// File: rtl/bitonic_sort_ctrl.sv
// bitonic_sort_ctrl: ready/valid front end for bitonic_sorter with an output FIFO and flush handling.
// Define SORT_CTRL_STATS_EN to add the sort_count / stall_count statistics outputs.
module bitonic_sort_ctrl
    import sort_pkg::*;
#(
    parameter int SORT_SIZE = `SORT_SIZE,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int SORT_LATENCY = SORT_LATENCY_DEF,
    parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] out_data,
    input  logic                                 flush
`ifdef SORT_CTRL_STATS_EN
    ,
    output logic [31:0]                          sort_count,
    output logic [31:0]                          stall_count
`endif
);
    localparam int IW = $clog2(SORT_LATENCY + 2);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int SW = $clog2(OUT_DEPTH + SORT_LATENCY + 3);
    state_t r_state, w_state_nxt;
    logic r_in_ready;
    logic [SORT_LATENCY:0] r_vld;
    logic [IW-1:0] r_inflight;
    logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] r_sort_in, w_sort_out;
    logic [CW-1:0] w_count;
    logic [SW-1:0] w_sum;
    logic w_acc, w_tail, w_push, w_pop;
    assign w_acc = in_valid && r_in_ready;
    assign w_tail = r_vld[SORT_LATENCY];
    assign w_push = w_tail && r_state == ST_RUN;
    assign out_valid = r_state == ST_RUN && w_count != '0;
    assign w_pop = out_valid && out_ready;
    assign in_ready = r_in_ready;
    // r_vld[0] marks the sorter input register; the tail sees the sorter output one edge after it settles.
    always_comb begin
        w_state_nxt = r_state == ST_RUN ? (flush ? ST_DRAIN : ST_RUN) :
                      r_state == ST_DRAIN ? (r_inflight == '0 ? ST_CLEAR : ST_DRAIN) : ST_RUN;
        w_sum = SW'(r_inflight) + (r_state == ST_CLEAR ? '0 : SW'(w_count)) + SW'(w_acc);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_in_ready <= 1'b0;
            r_vld <= '0;
            r_inflight <= '0;
            r_sort_in <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_in_ready <= w_state_nxt == ST_RUN && w_sum < SW'(OUT_DEPTH);
            r_vld <= {r_vld[SORT_LATENCY-1:0], w_acc};
            r_inflight <= r_inflight + IW'(w_acc) - IW'(w_tail);
            if (w_acc) r_sort_in <= in_data;
        end
    end
    bitonic_sorter #(.SORT_SIZE(SORT_SIZE), .DATA_WIDTH(DATA_WIDTH), .SORT_LATENCY(SORT_LATENCY)) u_sorter (
        .clk(clk),
        .data_in(r_sort_in),
        .data_out(w_sort_out)
    );
    sort_out_fifo #(.DEPTH(OUT_DEPTH), .W(SORT_SIZE * DATA_WIDTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .i_clr(r_state == ST_CLEAR),
        .i_push(w_push),
        .i_pop(w_pop),
        .i_data(w_sort_out),
        .o_data(out_data),
        .o_count(w_count)
    );
`ifdef SORT_CTRL_STATS_EN
    logic [31:0] r_sort_cnt, r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sort_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && r_sort_cnt != '1) r_sort_cnt <= r_sort_cnt + 1'b1;
            if (in_valid && !r_in_ready && r_state == ST_RUN && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
    assign sort_count = r_sort_cnt;
    assign stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// tb_bitonic_sort_ctrl: directed self-checking bench for bitonic_sort_ctrl (4 x 8-bit, latency 3, depth 4).
module tb_bitonic_sort_ctrl;
    typedef logic [3:0][7:0] vec_t;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, flush;
    vec_t in_data, out_data;
`ifdef SORT_CTRL_STATS_EN
    logic [31:0] sort_count, stall_count;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitonic_sort_ctrl #(.SORT_SIZE(4), .DATA_WIDTH(8), .SORT_LATENCY(3), .OUT_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .flush(flush)
`ifdef SORT_CTRL_STATS_EN
        ,
        .sort_count(sort_count),
        .stall_count(stall_count)
`endif
    );

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t sort_ref(input vec_t v);
        vec_t s = v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3 - i; j++)
                if (s[j] > s[j+1]) {s[j], s[j+1]} = {s[j+1], s[j]};
        return s;
    endfunction

    function automatic vec_t vin(input int n);
        return mk(8'(10*n+3), 8'(10*n), 8'(10*n+2), 8'(10*n+1));
    endfunction

    function automatic vec_t vexp(input int n);
        return mk(8'(10*n), 8'(10*n+1), 8'(10*n+2), 8'(10*n+3));
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        repeat (2) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_rise: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_single;
        in_data = mk(9, 3, 7, 1); in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_data = mk(0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (out_valid !== (c == 4)) begin errors++; $display("FAIL single_latency edge k+%0d: got %b want %b", c, out_valid, c == 4); end
        end
        checks++; if (out_data !== mk(1, 3, 7, 9)) begin errors++; $display("FAIL single_data: got %h want %h", out_data, mk(1, 3, 7, 9)); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        int t;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = vin(acc);
            if (in_ready) acc++;
            tick();
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL b2b_fill_count: got %0d want 4", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== vexp(0)) begin errors++; $display("FAIL b2b_head: got %b/%h want 1/%h", out_valid, out_data, vexp(0)); end
        in_data = vin(acc);
        if (in_ready) acc++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_data = vin(acc);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (acc != 5) begin errors++; $display("FAIL b2b_refill_count: got %0d want 5", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_refill_ready: got %b want 0", in_ready); end
        for (int n = 1; n < 5; n++) begin
            t = 0;
            while (!out_valid && t < 10) begin tick(); t++; end
            checks++;
            if (out_valid !== 1'b1 || out_data !== vexp(n)) begin errors++; $display("FAIL b2b_order %0d: got %b/%h want 1/%h", n, out_valid, out_data, vexp(n)); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_random;
        vec_t q[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int extra = 0;
        bit took;
        in_valid = 1'b0;
        while (got < 20 && cyc < 2000) begin
            if (!in_valid && sent < 20) begin in_data = $urandom; in_valid = 1'b1; end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rand_out %0d: got %h want nothing", got, out_data); end
                else begin
                    if (out_data !== q[0]) begin errors++; $display("FAIL rand_out %0d: got %h want %h", got, out_data, q[0]); end
                    q.pop_front();
                end
                got++;
            end
            took = in_valid && in_ready;
            if (took) begin q.push_back(sort_ref(in_data)); sent++; end
            tick(); cyc++;
            if (took) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) extra++;
            tick();
        end
        out_ready = 1'b0;
        checks++; if (got != 20 || sent != 20 || q.size() != 0) begin errors++; $display("FAIL rand_totals: got sent=%0d out=%0d left=%0d want 20/20/0", sent, got, q.size()); end
        checks++; if (extra != 0) begin errors++; $display("FAIL rand_duplicates: got %0d extra want 0", extra); end
    endtask

    task automatic test_flush;
        int extra = 0;
        int t;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mk(5, 4, 3, 2);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = mk(8, 7, 6, 9); tick();
        in_data = mk(1, 1, 2, 0); tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup: got %b want 1", out_valid); end
        flush = 1'b1; tick(); flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            checks++;
            if (in_ready !== (c == 5) || out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain step %0d: got %b/%b want %b/0", c, in_ready, out_valid, c == 5); end
            if (c < 5) tick();
        end
        for (int i = 0; i < 6; i++) begin
            if (out_valid) extra++;
            tick();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL flush_leak: got %0d outputs want 0", extra); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mk(200, 100, 150, 50); tick(); in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 10) begin tick(); t++; end
        checks++; if (out_valid !== 1'b1 || out_data !== mk(50, 100, 150, 200)) begin errors++; $display("FAIL flush_resume: got %b/%h want 1/%h", out_valid, out_data, mk(50, 100, 150, 200)); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight;
        int stale = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = mk(8'(50+i), 40, 30, 20);
            tick();
        end
        in_valid = 1'b0; rst = 1'b1; tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b/%b want 0/0", out_valid, in_ready); end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) stale++;
        end
        out_ready = 1'b0;
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d outputs want 0", stale); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    endtask

`ifdef SORT_CTRL_STATS_EN
    task automatic test_stats;
        int t;
        out_ready = 1'b0; in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (sort_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d want 0/0", sort_count, stall_count); end
        in_valid = 1'b1; in_data = mk(4, 3, 2, 1);
        repeat (6) tick();
        in_valid = 1'b0; out_ready = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        t = 0;
        while (sort_count != 32'd5 && t < 40) begin tick(); t++; end
        repeat (3) tick();
        checks++; if (sort_count !== 32'd5) begin errors++; $display("FAIL stats_sort_count: got %0d want 5", sort_count); end
        checks++; if (stall_count !== 32'd2) begin errors++; $display("FAIL stats_stall_count: got %0d want 2", stall_count); end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_midflight();
`ifdef SORT_CTRL_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
